// File: rtl/id_pkg.sv
// Shared constants for the ID stage: default widths, MIPS opcode/funct codes
// and the control-flow classification used by the hazard and branch logic.
package id_pkg;

  localparam int NB_REG_DEF  = 32;
  localparam int NB_ADDR_DEF = 5;
  localparam int NB_CNT_DEF  = 16;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  typedef enum logic [2:0] {
    CF_NONE,
    CF_BEQ,
    CF_BNE,
    CF_BLEZ,
    CF_BGTZ,
    CF_JUMPREG
  } cf_e;

  function automatic cf_e decode_cf(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_BEQ:     return CF_BEQ;
      OP_BNE:     return CF_BNE;
      OP_BLEZ:    return CF_BLEZ;
      OP_BGTZ:    return CF_BGTZ;
      OP_SPECIAL: return (fn == FN_JR || fn == FN_JALR) ? CF_JUMPREG : CF_NONE;
      default:    return CF_NONE;
    endcase
  endfunction

endpackage

// File: rtl/id_regfile.sv
// Register file with one write port and three read ports (rs, rt, debug);
// each read port sees a same-cycle write-back through a bypass.
module id_regfile
  import id_pkg::*;
#(
  parameter int NB_REG  = NB_REG_DEF,
  parameter int NB_ADDR = NB_ADDR_DEF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_en,
  input  logic               i_wb_we,
  input  logic [NB_ADDR-1:0] i_wb_addr,
  input  logic [NB_REG-1:0]  i_wb_data,
  input  logic [NB_ADDR-1:0] i_rs_addr,
  input  logic [NB_ADDR-1:0] i_rt_addr,
  input  logic [NB_ADDR-1:0] i_dbg_addr,
  output logic [NB_REG-1:0]  o_rs_data,
  output logic [NB_REG-1:0]  o_rt_data,
  output logic [NB_REG-1:0]  o_dbg_data
);

  localparam int NREG = 2 ** NB_ADDR;

  logic [NB_REG-1:0] regs_q [NREG];

  // NOTE: the whole array is cleared on reset because software relies on a
  // zeroed file after reset; this rules out mapping it onto a block RAM.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (i_en && i_wb_we && i_wb_addr != '0) begin
      regs_q[i_wb_addr] <= i_wb_data;
    end
  end

  function automatic logic [NB_REG-1:0] read_port(input logic [NB_ADDR-1:0] addr,
                                                  input logic [NB_REG-1:0]  stored);
    if (addr == '0)                        return '0;
    else if (i_wb_we && i_wb_addr == addr) return i_wb_data;
    else                                   return stored;
  endfunction

  assign o_rs_data  = read_port(i_rs_addr,  regs_q[i_rs_addr]);
  assign o_rt_data  = read_port(i_rt_addr,  regs_q[i_rt_addr]);
  assign o_dbg_data = read_port(i_dbg_addr, regs_q[i_dbg_addr]);

endmodule

// File: rtl/id_hazard_stage.sv
// Instruction-decode stage: register read, load-use/branch hazard detection,
// same-cycle branch resolution and the ID/EX pipeline register.
module id_hazard_stage
  import id_pkg::*;
#(
  parameter int NB_REG  = NB_REG_DEF,
  parameter int NB_ADDR = NB_ADDR_DEF,
  parameter int NB_CNT  = NB_CNT_DEF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_en,
  input  logic               i_valid,
  input  logic [NB_REG-1:0]  i_inst,
  input  logic [NB_REG-1:0]  i_pcplus4,
  input  logic               i_wb_we,
  input  logic [NB_ADDR-1:0] i_wb_addr,
  input  logic [NB_REG-1:0]  i_wb_data,
  input  logic               i_ex_we,
  input  logic               i_ex_memread,
  input  logic [NB_ADDR-1:0] i_ex_addr,
  input  logic               i_mem_we,
  input  logic               i_mem_memread,
  input  logic [NB_ADDR-1:0] i_mem_addr,
  input  logic [NB_REG-1:0]  i_mem_data,
  input  logic [NB_ADDR-1:0] i_dunit_addr,
  output logic [NB_REG-1:0]  o_dunit_reg,
  output logic               o_stall,
  output logic               o_flush,
  output logic               o_pcsrc,
  output logic [NB_REG-1:0]  o_pc_target,
  output logic               o_valid,
  output logic [NB_REG-1:0]  o_rs_data,
  output logic [NB_REG-1:0]  o_rt_data,
  output logic [NB_REG-1:0]  o_imm,
  output logic [NB_REG-1:0]  o_pcplus8,
  output logic [NB_ADDR-1:0] o_rs_addr,
  output logic [NB_ADDR-1:0] o_rt_addr,
  output logic [NB_ADDR-1:0] o_rd_addr,
  output logic [5:0]         o_opcode,
  output logic [5:0]         o_funct,
  output logic [NB_CNT-1:0]  o_stall_cnt
);

  typedef struct packed {
    logic               valid;
    logic [NB_REG-1:0]  rs_data;
    logic [NB_REG-1:0]  rt_data;
    logic [NB_REG-1:0]  imm;
    logic [NB_REG-1:0]  pcplus8;
    logic [NB_ADDR-1:0] rs_addr;
    logic [NB_ADDR-1:0] rt_addr;
    logic [NB_ADDR-1:0] rd_addr;
    logic [5:0]         opcode;
    logic [5:0]         funct;
  } idex_t;

  logic [5:0]         opcode, funct;
  logic [NB_ADDR-1:0] rs, rt, rd;
  logic [NB_REG-1:0]  imm_ext, rs_rf, rt_rf, rs_br, rt_br;
  cf_e                cf;
  logic               uses_rt, load_use, ex_hit, mem_hit, cond;
  idex_t              idex_q, idex_d;
  logic [NB_CNT-1:0]  cnt_q, cnt_d;

  assign opcode  = i_inst[31:26];
  assign rs      = i_inst[25:21];
  assign rt      = i_inst[20:16];
  assign rd      = i_inst[15:11];
  assign funct   = i_inst[5:0];
  assign imm_ext = {{(NB_REG-16){i_inst[15]}}, i_inst[15:0]};

  id_regfile #(.NB_REG(NB_REG), .NB_ADDR(NB_ADDR)) u_regfile (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_en       (i_en),
    .i_wb_we    (i_wb_we),
    .i_wb_addr  (i_wb_addr),
    .i_wb_data  (i_wb_data),
    .i_rs_addr  (rs),
    .i_rt_addr  (rt),
    .i_dbg_addr (i_dunit_addr),
    .o_rs_data  (rs_rf),
    .o_rt_data  (rt_rf),
    .o_dbg_data (o_dunit_reg)
  );

  // Branches resolve in ID, so an ALU result sitting in MEM is forwarded here;
  // a load in MEM has no data yet and is covered by the stall instead.
  assign rs_br = (i_mem_we && !i_mem_memread && i_mem_addr == rs && rs != '0) ? i_mem_data : rs_rf;
  assign rt_br = (i_mem_we && !i_mem_memread && i_mem_addr == rt && rt != '0) ? i_mem_data : rt_rf;

  assign cf       = decode_cf(opcode, funct);
  assign uses_rt  = (cf == CF_BEQ) || (cf == CF_BNE);
  assign load_use = i_ex_memread && i_ex_addr != '0 && (i_ex_addr == rs || i_ex_addr == rt);
  assign ex_hit   = i_ex_we && i_ex_addr != '0 &&
                    (i_ex_addr == rs || (uses_rt && i_ex_addr == rt));
  assign mem_hit  = i_mem_memread && i_mem_addr != '0 &&
                    (i_mem_addr == rs || (uses_rt && i_mem_addr == rt));

  assign o_stall  = i_en && i_valid && (load_use || (cf != CF_NONE && (ex_hit || mem_hit)));

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    cond = 1'b0;
    case (cf)
      CF_BEQ:     cond = (rs_br == rt_br);
      CF_BNE:     cond = (rs_br != rt_br);
      CF_BLEZ:    cond = rs_br[NB_REG-1] || (rs_br == '0);
      CF_BGTZ:    cond = !rs_br[NB_REG-1] && (rs_br != '0);
      CF_JUMPREG: cond = 1'b1;
      default:    cond = 1'b0;
    endcase
  end

  assign o_pcsrc     = i_en && i_valid && !o_stall && cond;
  assign o_flush     = o_pcsrc;
  assign o_pc_target = (cf == CF_JUMPREG) ? rs_br : i_pcplus4 + (imm_ext << 2);

  always_comb begin
    idex_d = idex_q;
    cnt_d  = cnt_q;
    if (i_en) begin
      if (o_stall) begin
        idex_d = '0;
      end else begin
        idex_d.valid   = i_valid;
        idex_d.rs_data = rs_rf;
        idex_d.rt_data = rt_rf;
        idex_d.imm     = imm_ext;
        idex_d.pcplus8 = i_pcplus4 + NB_REG'(4);
        idex_d.rs_addr = rs;
        idex_d.rt_addr = rt;
        idex_d.rd_addr = rd;
        idex_d.opcode  = opcode;
        idex_d.funct   = funct;
      end
    end
    if (o_stall && cnt_q != '1) cnt_d = cnt_q + NB_CNT'(1);
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      idex_q <= '0;
      cnt_q  <= '0;
    end else begin
      idex_q <= idex_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_valid     = idex_q.valid;
  assign o_rs_data   = idex_q.rs_data;
  assign o_rt_data   = idex_q.rt_data;
  assign o_imm       = idex_q.imm;
  assign o_pcplus8   = idex_q.pcplus8;
  assign o_rs_addr   = idex_q.rs_addr;
  assign o_rt_addr   = idex_q.rt_addr;
  assign o_rd_addr   = idex_q.rd_addr;
  assign o_opcode    = idex_q.opcode;
  assign o_funct     = idex_q.funct;
  assign o_stall_cnt = cnt_q;

endmodule

// File: tb/tb_id_hazard_stage.sv
// Directed bench for id_hazard_stage: a table of single-cycle vectors plus
// hand-written multi-cycle sequences for stalls, bypass, enable and reset.
module tb_id_hazard_stage;

  logic        i_clk, i_reset, i_en, i_valid;
  logic [31:0] i_inst, i_pcplus4;
  logic        i_wb_we;
  logic [4:0]  i_wb_addr;
  logic [31:0] i_wb_data;
  logic        i_ex_we, i_ex_memread;
  logic [4:0]  i_ex_addr;
  logic        i_mem_we, i_mem_memread;
  logic [4:0]  i_mem_addr;
  logic [31:0] i_mem_data;
  logic [4:0]  i_dunit_addr;
  logic [31:0] o_dunit_reg;
  logic        o_stall, o_flush, o_pcsrc;
  logic [31:0] o_pc_target;
  logic        o_valid;
  logic [31:0] o_rs_data, o_rt_data, o_imm, o_pcplus8;
  logic [4:0]  o_rs_addr, o_rt_addr, o_rd_addr;
  logic [5:0]  o_opcode, o_funct;
  logic [15:0] o_stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;

  id_hazard_stage dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_en(i_en), .i_valid(i_valid),
    .i_inst(i_inst), .i_pcplus4(i_pcplus4),
    .i_wb_we(i_wb_we), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
    .i_ex_we(i_ex_we), .i_ex_memread(i_ex_memread), .i_ex_addr(i_ex_addr),
    .i_mem_we(i_mem_we), .i_mem_memread(i_mem_memread), .i_mem_addr(i_mem_addr),
    .i_mem_data(i_mem_data), .i_dunit_addr(i_dunit_addr), .o_dunit_reg(o_dunit_reg),
    .o_stall(o_stall), .o_flush(o_flush), .o_pcsrc(o_pcsrc), .o_pc_target(o_pc_target),
    .o_valid(o_valid), .o_rs_data(o_rs_data), .o_rt_data(o_rt_data), .o_imm(o_imm),
    .o_pcplus8(o_pcplus8), .o_rs_addr(o_rs_addr), .o_rt_addr(o_rt_addr),
    .o_rd_addr(o_rd_addr), .o_opcode(o_opcode), .o_funct(o_funct),
    .o_stall_cnt(o_stall_cnt)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  typedef struct {
    logic        valid;
    logic [31:0] inst, pc4;
    logic        ex_we, ex_mr;
    logic [4:0]  ex_a;
    logic        mem_we, mem_mr;
    logic [4:0]  mem_a;
    logic [31:0] mem_d;
    logic        e_stall, e_pcsrc, chk_tgt;
    logic [31:0] e_tgt;
    logic        e_valid;
    logic [31:0] e_rs, e_rt, e_imm;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    i_en = 1'b1; i_valid = 1'b0; i_inst = '0; i_pcplus4 = 32'h100;
    i_wb_we = 1'b0; i_wb_addr = '0; i_wb_data = '0;
    i_ex_we = 1'b0; i_ex_memread = 1'b0; i_ex_addr = '0;
    i_mem_we = 1'b0; i_mem_memread = 1'b0; i_mem_addr = '0; i_mem_data = '0;
    i_dunit_addr = '0;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    idle();
    i_wb_we = 1'b1; i_wb_addr = a; i_wb_data = d;
    tick();
    i_wb_we = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    idle();
    i_valid = v.valid; i_inst = v.inst; i_pcplus4 = v.pc4;
    i_ex_we = v.ex_we; i_ex_memread = v.ex_mr; i_ex_addr = v.ex_a;
    i_mem_we = v.mem_we; i_mem_memread = v.mem_mr; i_mem_addr = v.mem_a; i_mem_data = v.mem_d;
    #1;
    check($sformatf("v%0d stall", idx), o_stall, v.e_stall);
    check($sformatf("v%0d pcsrc", idx), o_pcsrc, v.e_pcsrc);
    check($sformatf("v%0d flush", idx), o_flush, v.e_pcsrc);
    if (v.chk_tgt) check($sformatf("v%0d target", idx), o_pc_target, v.e_tgt);
    if (v.e_stall) exp_cnt++;
    tick();
    check($sformatf("v%0d valid", idx), o_valid, v.e_valid);
    check($sformatf("v%0d rs_data", idx), o_rs_data, v.e_rs);
    check($sformatf("v%0d rt_data", idx), o_rt_data, v.e_rt);
    check($sformatf("v%0d imm", idx), o_imm, v.e_imm);
  endtask

  initial begin
    // valid inst pc4 | ex_we ex_mr ex_a | mem_we mem_mr mem_a mem_d | stall pcsrc chk tgt | valid rs rt imm
    vecs[0]  = '{1, 32'h00441820, 32'h100, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0,      1, 10, 20, 32'h1820};
    vecs[1]  = '{1, 32'h00441820, 32'h100, 1, 1, 2, 0, 0, 0, 0,     1, 0, 0, 0,      0, 0, 0, 0};
    vecs[2]  = '{1, 32'h00441820, 32'h100, 1, 1, 4, 0, 0, 0, 0,     1, 0, 0, 0,      0, 0, 0, 0};
    vecs[3]  = '{1, 32'h00441820, 32'h100, 1, 0, 2, 0, 0, 0, 0,     0, 0, 0, 0,      1, 10, 20, 32'h1820};
    vecs[4]  = '{1, 32'h00441820, 32'h100, 0, 0, 0, 1, 1, 2, 0,     0, 0, 0, 0,      1, 10, 20, 32'h1820};
    vecs[5]  = '{1, 32'h1CE00002, 32'h100, 0, 0, 0, 0, 0, 0, 0,     0, 0, 1, 32'h108, 1, 32'h80000000, 0, 2};
    vecs[6]  = '{1, 32'h18E00002, 32'h100, 0, 0, 0, 0, 0, 0, 0,     0, 1, 1, 32'h108, 1, 32'h80000000, 0, 2};
    vecs[7]  = '{1, 32'h01000008, 32'h100, 0, 0, 0, 0, 0, 0, 0,     0, 1, 1, 32'h40,  1, 32'h40, 0, 8};
    vecs[8]  = '{1, 32'h01000009, 32'h100, 0, 0, 0, 1, 0, 8, 32'h80, 0, 1, 1, 32'h80, 1, 32'h40, 0, 9};
    vecs[9]  = '{1, 32'h10A6FFFF, 32'h100, 0, 0, 0, 1, 0, 5, 7,     0, 1, 1, 32'hFC,  1, 0, 7, 32'hFFFFFFFF};
    vecs[10] = '{1, 32'h10A6FFFF, 32'h100, 0, 0, 0, 1, 1, 6, 0,     1, 0, 0, 0,      0, 0, 0, 0};
    vecs[11] = '{1, 32'h18E60002, 32'h100, 1, 0, 6, 0, 0, 0, 0,     0, 1, 1, 32'h108, 1, 32'h80000000, 7, 2};
    vecs[12] = '{0, 32'h00441820, 32'h100, 1, 1, 2, 0, 0, 0, 0,     0, 0, 0, 0,      0, 10, 20, 32'h1820};
    vecs[13] = '{1, 32'h10000003, 32'h100, 1, 0, 0, 0, 0, 0, 0,     0, 1, 1, 32'h10C, 1, 0, 0, 3};

    idle();
    i_reset = 1'b1;
    #7;
    check("reset valid", o_valid, 0);
    check("reset cnt", o_stall_cnt, 0);
    check("reset rs_data", o_rs_data, 0);
    tick();
    i_reset = 1'b0;

    wb_write(2, 10);
    wb_write(4, 20);
    wb_write(6, 7);
    wb_write(7, 32'h80000000);
    wb_write(8, 32'h40);

    // lw $2 in EX, add $3,$2,$4 in ID
    idle();
    i_valid = 1; i_inst = 32'h00441820; i_ex_we = 1; i_ex_memread = 1; i_ex_addr = 2;
    #1;
    check("lu stall", o_stall, 1);
    check("lu cnt before", o_stall_cnt, 0);
    tick();
    exp_cnt++;
    check("lu bubble", o_valid, 0);
    check("lu cnt after", o_stall_cnt, 1);

    for (int i = 0; i < 14; i++) apply_vec(vecs[i], i);
    check("table cnt", o_stall_cnt, 16'(exp_cnt));

    // add $5 in EX then MEM, beq $5,$6 in ID
    idle();
    i_valid = 1; i_inst = 32'h10A6FFFF; i_ex_we = 1; i_ex_addr = 5;
    #1;
    check("beq ex stall", o_stall, 1);
    check("beq ex pcsrc", o_pcsrc, 0);
    tick();
    exp_cnt++;
    i_ex_we = 0; i_ex_addr = 0; i_mem_we = 1; i_mem_addr = 5; i_mem_data = 7;
    #1;
    check("beq mem stall", o_stall, 0);
    check("beq mem pcsrc", o_pcsrc, 1);
    check("beq target", o_pc_target, 32'hFC);
    tick();
    check("beq cnt", o_stall_cnt, 16'(exp_cnt));

    // WB write and ID read of $9 in the same cycle; $0 write ignored
    idle();
    i_valid = 1; i_inst = 32'h01205020; i_wb_we = 1; i_wb_addr = 9; i_wb_data = 32'hA5;
    tick();
    check("wb bypass rs", o_rs_data, 32'hA5);
    check("wb rd_addr", o_rd_addr, 10);
    check("wb funct", o_funct, 6'h20);
    check("wb pcplus8", o_pcplus8, 32'h104);
    idle();
    i_valid = 1; i_inst = 32'h00005020; i_wb_we = 1; i_wb_addr = 0; i_wb_data = 32'h55;
    i_dunit_addr = 0;
    #1;
    check("r0 debug", o_dunit_reg, 0);
    tick();
    check("r0 rs_data", o_rs_data, 0);
    idle();
    i_dunit_addr = 9;
    #1;
    check("r9 stored", o_dunit_reg, 32'hA5);

    // lw $5 in EX, bne $5,$0: two stalls then WB bypass of 0
    wb_write(5, 3);
    idle();
    i_valid = 1; i_inst = 32'h14A00004; i_pcplus4 = 32'h200;
    i_ex_we = 1; i_ex_memread = 1; i_ex_addr = 5;
    #1;
    check("bne stall1", o_stall, 1);
    tick();
    exp_cnt++;
    i_ex_we = 0; i_ex_memread = 0; i_ex_addr = 0;
    i_mem_we = 1; i_mem_memread = 1; i_mem_addr = 5;
    #1;
    check("bne stall2", o_stall, 1);
    tick();
    exp_cnt++;
    i_mem_we = 0; i_mem_memread = 0; i_mem_addr = 0;
    i_wb_we = 1; i_wb_addr = 5; i_wb_data = 0;
    #1;
    check("bne stall3", o_stall, 0);
    check("bne pcsrc", o_pcsrc, 0);
    tick();
    check("bne cnt", o_stall_cnt, 16'(exp_cnt));

    // enable low freezes state and masks control outputs
    idle();
    i_valid = 1; i_inst = 32'h00441820;
    tick();
    idle();
    i_en = 0; i_valid = 1; i_inst = 32'h00441820; i_ex_memread = 1; i_ex_addr = 2;
    i_wb_we = 1; i_wb_addr = 11; i_wb_data = 32'h77;
    #1;
    check("en0 stall", o_stall, 0);
    tick();
    i_wb_we = 0; i_ex_memread = 0; i_ex_addr = 0; i_inst = 32'h18E00002;
    #1;
    check("en0 pcsrc", o_pcsrc, 0);
    check("en0 flush", o_flush, 0);
    tick();
    check("en0 rs_data held", o_rs_data, 10);
    check("en0 imm held", o_imm, 32'h1820);
    check("en0 cnt held", o_stall_cnt, 16'(exp_cnt));
    idle();
    i_dunit_addr = 11;
    #1;
    check("en0 no write", o_dunit_reg, 0);

    // stall counter saturation, then asynchronous reset mid-stall
    idle();
    i_valid = 1; i_inst = 32'h00441820; i_ex_memread = 1; i_ex_addr = 2;
    repeat (65540) @(posedge i_clk);
    #1;
    check("cnt saturate", o_stall_cnt, 16'hFFFF);
    #1;
    i_reset = 1'b1;
    #1;
    check("arst cnt", o_stall_cnt, 0);
    check("arst valid", o_valid, 0);
    check("arst imm", o_imm, 0);
    check("arst pcplus8", o_pcplus8, 0);
    i_dunit_addr = 8;
    #1;
    check("arst regfile", o_dunit_reg, 0);
    tick();
    i_reset = 1'b0;
    i_ex_memread = 0; i_ex_addr = 0;
    #1;
    check("post rst stall", o_stall, 0);
    tick();
    check("post rst valid", o_valid, 1);
    check("post rst cnt", o_stall_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_hazard_stage.md
ID_HAZARD_STAGE -- requirements
Module: id_hazard_stage

Interface
REQ-001 Parameters: NB_REG 32 data width; NB_ADDR 5 register-address width; NB_CNT 16 stall-counter width.
REQ-002 i_clk  in  1  single clock, rising edge; i_reset  in  1  asynchronous, active-high reset.
REQ-003 i_en  in  1  debug-unit clock enable; i_valid  in  1  IF/ID holds a real instruction.
REQ-004 i_inst  in  NB_REG  instruction; i_pcplus4  in  NB_REG  PC+4 of that instruction.
REQ-005 i_wb_we, i_wb_addr, i_wb_data  in  1/NB_ADDR/NB_REG  write-back port.
REQ-006 i_ex_we, i_ex_memread, i_ex_addr  in  1/1/NB_ADDR  destination info of instruction in EX.
REQ-007 i_mem_we, i_mem_memread, i_mem_addr, i_mem_data  in  1/1/NB_ADDR/NB_REG  MEM-stage destination and ALU result.
REQ-008 i_dunit_addr  in  NB_ADDR; o_dunit_reg  out  NB_REG  combinational debug read.
REQ-009 o_stall  out  1  hold PC and IF/ID; o_flush  out  1  squash IF/ID; o_pcsrc  out  1  take o_pc_target; o_pc_target  out  NB_REG.
REQ-010 Registered ID/EX outputs: o_valid 1, o_rs_data/o_rt_data/o_imm/o_pcplus8 NB_REG, o_rs_addr/o_rt_addr/o_rd_addr NB_ADDR, o_opcode/o_funct 6.
REQ-011 o_stall_cnt  out  NB_CNT  saturating count of stall cycles.

Function
REQ-012 Register file: 2**NB_ADDR entries, written on rising edge when i_en & i_wb_we & i_wb_addr!=0; register 0 reads zero always.
REQ-013 Read bypass: if i_wb_we & i_wb_addr==read address & address!=0, read returns i_wb_data the same cycle (applies to rs, rt, debug port).
REQ-014 Decoded control-flow: BEQ 000100, BNE 000101, BLEZ 000110, BGTZ 000111, JR op 0/funct 001000, JALR op 0/funct 001001.
REQ-015 Branch operands: if i_mem_we & !i_mem_memread & i_mem_addr matches & !=0 use i_mem_data, else bypassed regfile value.
REQ-016 Load-use stall: i_ex_memread & i_ex_addr!=0 & i_ex_addr equals rs or rt field.
REQ-017 Branch stall (control-flow instr only): i_ex_we & i_ex_addr!=0 matching a used operand; or i_mem_memread & i_mem_addr!=0 matching a used operand; used operands: rs,rt for BEQ/BNE; rs only for BLEZ/BGTZ/JR/JALR.
REQ-018 o_stall = i_en & i_valid & (REQ-016 | REQ-017); all combinational.
REQ-019 Conditions: BEQ rs==rt; BNE rs!=rt; BLEZ signed rs<=0; BGTZ signed rs>0; JR/JALR always.
REQ-020 o_pcsrc = o_flush = i_en & i_valid & !o_stall & condition true; no delay slot.
REQ-021 o_pc_target: branches i_pcplus4 + (sign-extended imm << 2) modulo 2**NB_REG; JR/JALR forwarded rs value.
REQ-022 ID/EX load each i_en cycle: on o_stall a bubble (o_valid=0, all other ID/EX outputs 0); otherwise o_valid=i_valid and decoded fields, bypassed rs/rt data, sign-extended imm, i_pcplus4+4.
REQ-023 Latency: decode fields appear on ID/EX outputs one cycle after presentation; branch resolution is same-cycle.
REQ-024 i_en low: no register, regfile or counter updates; o_stall, o_pcsrc, o_flush forced 0.
REQ-025 o_stall_cnt increments on each cycle with o_stall=1, saturates at all-ones, never wraps.
REQ-026 Simultaneous WB write and stall: write still occurs; bypass applies in the same cycle.

Reset
REQ-027 i_reset asserts asynchronously: all regfile entries, ID/EX outputs and o_stall_cnt go to 0; o_valid 0.
REQ-028 Reset mid-stall: next cycle after deassertion treats IF/ID contents as new; no stall history kept.

Structure
REQ-029 Package id_pkg holds opcode/funct constants and default NB_REG/NB_ADDR.
REQ-030 One sub-module id_regfile: storage, write port, three bypassed read ports (rs, rt, debug).

Verification
REQ-031 lw $2 in EX, add $3,$2,$4 in ID -> o_stall=1 one cycle, bubble o_valid=0, o_stall_cnt 0->1.
REQ-032 add $5 in EX, beq $5,$6 in ID -> stall 1 cycle; next cycle MEM forward 7, $6=7 -> o_pcsrc=1, target pcplus4 0x100 + imm 0xFFFF<<2 = 0xFC.
REQ-033 lw $5 in EX, bne $5,$0 -> two stall cycles, then resolves using WB bypass of 0 -> o_pcsrc=0.
REQ-034 WB writes $9=0xA5 while ID reads $9 -> o_rs_data=0xA5 next cycle; write to $0 ignored, reads 0.
REQ-035 bgtz with rs=0x80000000 -> not taken; blez same -> taken; jr rs=0x40 -> o_pc_target=0x40.
REQ-036 Force 0xFFFF stalls -> o_stall_cnt holds 0xFFFF; i_reset mid-run -> all outputs 0 immediately.
